// File: rtl/mc_control.sv
// mc_control: multi-cycle sequencer for the MIPS-subset CPU. It owns the shared ALU
// selector and steps each instruction through fetch/decode/execute/memory/writeback.
module mc_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        mem_ready,
  output logic [5:0]  alu_opcode,
  output logic        alu_sig,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        exc,
  output logic        halted,
  output logic [3:0]  state
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_LOAD_WB = 4'd7,
    S_WB      = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_HALT    = 4'd15
  } state_t;

  state_t        state_r;
  logic          ovf_r;
  logic [CW-1:0] wait_cnt_r;
  logic [5:0]    op_s;
  logic [5:0]    fn_s;
  logic          mem_wait_s;
  logic          timeout_s;

  assign op_s       = instr[31:26];
  assign fn_s       = instr[5:0];
  assign state      = state_r;
  assign mem_wait_s = ((state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR))
                      && !mem_ready;
  assign timeout_s  = mem_wait_s && (wait_cnt_r == CW'(MEM_WAIT_MAX - 1));

  function automatic logic r_funct_ok(input logic [5:0] f);
    case (f)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
      6'h2A, 6'h2B: r_funct_ok = 1'b1;
      default:      r_funct_ok = 1'b0;
    endcase
  endfunction

  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t nxt;
    case (op)
      6'h00: begin
        if ((fn == 6'h08) || (fn == 6'h09)) nxt = S_JUMP;
        else if (r_funct_ok(fn))            nxt = S_EXEC_R;
        else                                nxt = S_HALT;
      end
      6'h02, 6'h03:                      nxt = S_JUMP;
      6'h04, 6'h05:                      nxt = S_BRANCH;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:        nxt = S_EXEC_I;
      6'h23, 6'h2B:                      nxt = S_ADDR;
      default:                           nxt = S_HALT;
    endcase
    return nxt;
  endfunction

  // Sequencer state, overflow latch (sampled only in execute) and memory wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_FETCH;
      ovf_r      <= 1'b0;
      wait_cnt_r <= '0;
    end else begin
      if (mem_wait_s && !timeout_s) wait_cnt_r <= wait_cnt_r + 1'b1;
      else                          wait_cnt_r <= '0;
      if ((state_r == S_EXEC_R) || (state_r == S_EXEC_I)) ovf_r <= alu_overflow;
      else                                                 ovf_r <= 1'b0;
      case (state_r)
        S_FETCH: begin
          if (mem_ready)      state_r <= S_DECODE;
          else if (timeout_s) state_r <= S_HALT;
          else                state_r <= S_FETCH;
        end
        S_DECODE:  state_r <= decode_next(op_s, fn_s);
        S_EXEC_R:  state_r <= S_WB;
        S_EXEC_I:  state_r <= S_WB;
        S_ADDR:    state_r <= (op_s == 6'h23) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (mem_ready)      state_r <= S_LOAD_WB;
          else if (timeout_s) state_r <= S_HALT;
          else                state_r <= S_MEM_RD;
        end
        S_MEM_WR: begin
          if (mem_ready)      state_r <= S_FETCH;
          else if (timeout_s) state_r <= S_HALT;
          else                state_r <= S_MEM_WR;
        end
        S_LOAD_WB: state_r <= S_FETCH;
        S_WB:      state_r <= S_FETCH;
        S_BRANCH:  state_r <= S_FETCH;
        S_JUMP:    state_r <= S_FETCH;
        S_HALT:    state_r <= S_HALT;
        default:   state_r <= S_HALT;
      endcase
    end
  end

  // Moore decode of the datapath controls; rst forces every enable low immediately.
  always_comb begin
    alu_opcode = 6'h00;
    alu_sig    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    rf_we      = 1'b0;
    reg_dst    = 2'd0;
    wb_sel     = 2'd0;
    exc        = 1'b0;
    halted     = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_sig    = 1'b1;
        alu_opcode = 6'h21;
        alu_src_b  = 2'd1;
        ir_we      = mem_ready;
        pc_we      = mem_ready;
      end
      S_DECODE: begin
        alu_sig    = 1'b1;
        alu_opcode = 6'h21;
        alu_src_b  = 2'd3;
      end
      S_EXEC_R: begin
        alu_sig    = 1'b1;
        alu_opcode = fn_s;
        alu_src_a  = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        alu_opcode = op_s;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      S_LOAD_WB: begin
        rf_we  = 1'b1;
        wb_sel = 2'd1;
      end
      S_WB: begin
        reg_dst = (op_s == 6'h00) ? 2'd1 : 2'd0;
        rf_we   = !ovf_r;
        exc     = ovf_r;
      end
      S_BRANCH: begin
        alu_sig    = 1'b1;
        alu_opcode = 6'h23;
        alu_src_a  = 1'b1;
        pc_src     = 2'd1;
        if (op_s == 6'h04)      pc_we = alu_zero;
        else if (op_s == 6'h05) pc_we = !alu_zero;
        else                    pc_we = 1'b0;
      end
      S_JUMP: begin
        pc_we = 1'b1;
        case (op_s)
          6'h02: pc_src = 2'd2;
          6'h03: begin
            pc_src  = 2'd2;
            rf_we   = 1'b1;
            reg_dst = 2'd2;
            wb_sel  = 2'd2;
          end
          default: begin
            pc_src = 2'd3;
            if (fn_s == 6'h09) begin
              rf_we   = 1'b1;
              reg_dst = 2'd1;
              wb_sel  = 2'd2;
            end else begin
              rf_we   = 1'b0;
            end
          end
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
    if (rst) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      rf_we   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      exc     = 1'b0;
      halted  = 1'b0;
    end else begin
      halted  = halted;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Table-driven bench for mc_control: per-cycle input/expected-output rows pushed
// through a scoreboard queue, plus hand-written reset and wait-timeout sequences.
module tb_mc_control;
  localparam logic [31:0] I_ADD   = 32'h012A4020;
  localparam logic [31:0] I_ADDI  = 32'h21280005;
  localparam logic [31:0] I_LW    = 32'h8D280004;
  localparam logic [31:0] I_SW    = 32'hAD280004;
  localparam logic [31:0] I_BEQ   = 32'h11090003;
  localparam logic [31:0] I_BNE   = 32'h15090003;
  localparam logic [31:0] I_JAL   = 32'h0C000010;
  localparam logic [31:0] I_JR    = 32'h01200008;
  localparam logic [31:0] I_JALR  = 32'h01200009;
  localparam logic [31:0] I_J     = 32'h08000010;
  localparam logic [31:0] I_ILL   = 32'hFC000000;
  localparam logic [31:0] I_BADFN = 32'h00000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        alu_overflow = 1'b0;
  logic        mem_ready = 1'b1;
  logic [5:0]  alu_opcode;
  logic        alu_sig, alu_src_a, mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, exc, halted;
  logic [1:0]  alu_src_b, pc_src, reg_dst, wb_sel;
  logic [3:0]  state;

  mc_control #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .mem_ready(mem_ready), .alu_opcode(alu_opcode), .alu_sig(alu_sig), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .exc(exc), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // {state, opcode, sig, src_a, src_b, {pc_we,ir_we,rf_we,mem_req,mem_we}, addr_sel, pc_src, reg_dst, wb_sel, exc, halted}
  typedef logic [27:0] exp_t;
  typedef struct {
    string       name;
    logic [31:0] i;
    logic        ov;
    logic        z;
    logic        r;
    exp_t        e;
  } row_t;

  row_t rows[$];
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  exp_t F_RDY, F_WAIT, F_RST, DEC, HALT_E;

  function automatic exp_t mk(input logic [3:0] st, input logic [5:0] opc, input logic sig,
                              input logic sa, input logic [1:0] sb, input logic [4:0] en,
                              input logic ad, input logic [1:0] pcs, input logic [1:0] rd,
                              input logic [1:0] wb, input logic ex, input logic h);
    return {st, opc, sig, sa, sb, en, ad, pcs, rd, wb, ex, h};
  endfunction

  function automatic exp_t act();
    return {state, alu_opcode, alu_sig, alu_src_a, alu_src_b,
            pc_we, ir_we, rf_we, mem_req, mem_we, addr_sel, pc_src, reg_dst, wb_sel, exc, halted};
  endfunction

  function automatic void add(input string n, input logic [31:0] i, input logic ov,
                              input logic z, input logic r, input exp_t e);
    row_t rw;
    rw.name = n; rw.i = i; rw.ov = ov; rw.z = z; rw.r = r; rw.e = e;
    rows.push_back(rw);
  endfunction

  task automatic check(input string nm);
    exp_t e;
    exp_t a;
    checks++;
    a = act();
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, actual=%h", nm, a);
    end else begin
      e = sb_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: actual=%h required=%h (state %0d)", nm, a, e, state);
      end
    end
  endtask

  // Called at a falling edge: drive, check mid-cycle, then move to the next falling edge.
  task automatic step(input string nm, input logic [31:0] i, input logic ov, input logic z,
                      input logic r, input exp_t e);
    instr = i; alu_overflow = ov; alu_zero = z; mem_ready = r;
    sb_q.push_back(e);
    #2;
    check(nm);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    F_RDY  = mk(4'd0, 6'h21, 1'b1, 1'b0, 2'd1, 5'b11010, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    F_WAIT = mk(4'd0, 6'h21, 1'b1, 1'b0, 2'd1, 5'b00010, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    F_RST  = mk(4'd0, 6'h21, 1'b1, 1'b0, 2'd1, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    DEC    = mk(4'd1, 6'h21, 1'b1, 1'b0, 2'd3, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    HALT_E = mk(4'd15, 6'h00, 1'b0, 1'b0, 2'd0, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);

    add("add_fetch", I_ADD, 1'b0, 1'b0, 1'b1, F_RDY);
    add("add_dec",   I_ADD, 1'b1, 1'b0, 1'b1, DEC);
    add("add_exec",  I_ADD, 1'b0, 1'b0, 1'b1, mk(4'd2, 6'h20, 1'b1, 1'b1, 2'd0, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    add("add_wb",    I_ADD, 1'b0, 1'b0, 1'b1, mk(4'd8, 6'h00, 1'b0, 1'b0, 2'd0, 5'b00100, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0));
    add("ovf_fetch", I_ADD, 1'b0, 1'b0, 1'b1, F_RDY);
    add("ovf_dec",   I_ADD, 1'b0, 1'b0, 1'b1, DEC);
    add("ovf_exec",  I_ADD, 1'b1, 1'b0, 1'b1, mk(4'd2, 6'h20, 1'b1, 1'b1, 2'd0, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    add("ovf_wb",    I_ADD, 1'b0, 1'b0, 1'b1, mk(4'd8, 6'h00, 1'b0, 1'b0, 2'd0, 5'b00000, 1'b0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0));
    add("ovf_after", I_ADDI, 1'b1, 1'b0, 1'b1, F_RDY);
    add("addi_dec",  I_ADDI, 1'b0, 1'b0, 1'b1, DEC);
    add("addi_exec", I_ADDI, 1'b0, 1'b0, 1'b1, mk(4'd3, 6'h08, 1'b0, 1'b1, 2'd2, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    add("addi_wb",   I_ADDI, 1'b0, 1'b0, 1'b1, mk(4'd8, 6'h00, 1'b0, 1'b0, 2'd0, 5'b00100, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    add("lw_fetch",  I_LW, 1'b0, 1'b0, 1'b1, F_RDY);
    add("lw_dec",    I_LW, 1'b0, 1'b0, 1'b1, DEC);
    add("lw_addr",   I_LW, 1'b0, 1'b0, 1'b1, mk(4'd4, 6'h23, 1'b0, 1'b1, 2'd2, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++)
      add("lw_wait", I_LW, 1'b0, 1'b0, 1'b0, mk(4'd5, 6'h00, 1'b0, 1'b0, 2'd0, 5'b00010, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    add("lw_mem",    I_LW, 1'b0, 1'b0, 1'b1, mk(4'd5, 6'h00, 1'b0, 1'b0, 2'd0, 5'b00010, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    add("lw_wb",     I_LW, 1'b0, 1'b0, 1'b1, mk(4'd7, 6'h00, 1'b0, 1'b0, 2'd0, 5'b00100, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0));
    add("sw_fetch",  I_SW, 1'b0, 1'b0, 1'b1, F_RDY);
    add("sw_dec",    I_SW, 1'b0, 1'b0, 1'b1, DEC);
    add("sw_addr",   I_SW, 1'b0, 1'b0, 1'b1, mk(4'd4, 6'h2B, 1'b0, 1'b1, 2'd2, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    add("sw_mem",    I_SW, 1'b0, 1'b0, 1'b1, mk(4'd6, 6'h00, 1'b0, 1'b0, 2'd0, 5'b00011, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    add("beq_fetch", I_BEQ, 1'b0, 1'b0, 1'b1, F_RDY);
    add("beq_dec",   I_BEQ, 1'b0, 1'b0, 1'b1, DEC);
    add("beq_taken", I_BEQ, 1'b0, 1'b1, 1'b1, mk(4'd9, 6'h23, 1'b1, 1'b1, 2'd0, 5'b10000, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0));
    add("bne_fetch", I_BNE, 1'b0, 1'b0, 1'b1, F_RDY);
    add("bne_dec",   I_BNE, 1'b0, 1'b0, 1'b1, DEC);
    add("bne_not",   I_BNE, 1'b0, 1'b1, 1'b1, mk(4'd9, 6'h23, 1'b1, 1'b1, 2'd0, 5'b00000, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0));
    add("beq_fetch", I_BEQ, 1'b0, 1'b0, 1'b1, F_RDY);
    add("beq_dec",   I_BEQ, 1'b0, 1'b0, 1'b1, DEC);
    add("beq_not",   I_BEQ, 1'b0, 1'b0, 1'b1, mk(4'd9, 6'h23, 1'b1, 1'b1, 2'd0, 5'b00000, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0));
    add("jal_fetch", I_JAL, 1'b0, 1'b0, 1'b1, F_RDY);
    add("jal_dec",   I_JAL, 1'b0, 1'b0, 1'b1, DEC);
    add("jal",       I_JAL, 1'b0, 1'b0, 1'b1, mk(4'd10, 6'h00, 1'b0, 1'b0, 2'd0, 5'b10100, 1'b0, 2'd2, 2'd2, 2'd2, 1'b0, 1'b0));
    add("jr_fetch",  I_JR, 1'b0, 1'b0, 1'b1, F_RDY);
    add("jr_dec",    I_JR, 1'b0, 1'b0, 1'b1, DEC);
    add("jr",        I_JR, 1'b0, 1'b0, 1'b1, mk(4'd10, 6'h00, 1'b0, 1'b0, 2'd0, 5'b10000, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0));
    add("jalr_fetch", I_JALR, 1'b0, 1'b0, 1'b1, F_RDY);
    add("jalr_dec",  I_JALR, 1'b0, 1'b0, 1'b1, DEC);
    add("jalr",      I_JALR, 1'b0, 1'b0, 1'b1, mk(4'd10, 6'h00, 1'b0, 1'b0, 2'd0, 5'b10100, 1'b0, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0));
    add("j_fetch",   I_J, 1'b0, 1'b0, 1'b1, F_RDY);
    add("j_dec",     I_J, 1'b0, 1'b0, 1'b1, DEC);
    add("j",         I_J, 1'b0, 1'b0, 1'b1, mk(4'd10, 6'h00, 1'b0, 1'b0, 2'd0, 5'b10000, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0));
    add("ill_fetch", I_ILL, 1'b0, 1'b0, 1'b1, F_RDY);
    add("ill_dec",   I_ILL, 1'b0, 1'b0, 1'b1, DEC);
    for (int k = 0; k < 3; k++)
      add("halt_hold", I_ILL, 1'b1, 1'b1, 1'b1, HALT_E);

    // Reset state while rst is held, mem_ready high must not enable anything.
    #2;
    sb_q.push_back(F_RST);
    check("reset_state");
    @(negedge clk);
    rst = 1'b0;

    foreach (rows[k]) step(rows[k].name, rows[k].i, rows[k].ov, rows[k].z, rows[k].r, rows[k].e);

    // Unsupported R-type funct also halts.
    do_reset();
    step("badfn_fetch", I_BADFN, 1'b0, 1'b0, 1'b1, F_RDY);
    step("badfn_dec",   I_BADFN, 1'b0, 1'b0, 1'b1, DEC);
    step("badfn_halt",  I_BADFN, 1'b0, 1'b0, 1'b1, HALT_E);

    // Asynchronous reset in the middle of a store.
    do_reset();
    step("sw2_fetch", I_SW, 1'b0, 1'b0, 1'b1, F_RDY);
    step("sw2_dec",   I_SW, 1'b0, 1'b0, 1'b1, DEC);
    step("sw2_addr",  I_SW, 1'b0, 1'b0, 1'b1, mk(4'd4, 6'h2B, 1'b0, 1'b1, 2'd2, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    step("sw2_wait",  I_SW, 1'b0, 1'b0, 1'b0, mk(4'd6, 6'h00, 1'b0, 1'b0, 2'd0, 5'b00011, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
    mem_ready = 1'b1;
    #1;
    rst = 1'b1;
    sb_q.push_back(F_RST);
    #1;
    check("rst_async");
    @(negedge clk);
    sb_q.push_back(F_RST);
    #1;
    check("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_wait",  I_ADD, 1'b0, 1'b0, 1'b0, F_WAIT);
    step("post_rst_fetch", I_ADD, 1'b0, 1'b0, 1'b1, F_RDY);

    // 14 idle memory cycles is still within budget.
    do_reset();
    for (int k = 0; k < 14; k++) step("wait14", I_ADD, 1'b0, 1'b0, 1'b0, F_WAIT);
    step("wait14_fetch", I_ADD, 1'b0, 1'b0, 1'b1, F_RDY);
    step("wait14_dec",   I_ADD, 1'b0, 1'b0, 1'b1, DEC);

    // 15 idle memory cycles in FETCH raise the timeout and halt.
    do_reset();
    for (int k = 0; k < 15; k++) step("wait15", I_ADD, 1'b0, 1'b0, 1'b0, F_WAIT);
    step("timeout_halt", I_ADD, 1'b0, 1'b0, 1'b1, HALT_E);
    step("timeout_hold", I_ADD, 1'b0, 1'b0, 1'b1, HALT_E);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle sequencer for the MIPS-subset CPU. Owns the shared 32-bit ALU and issues its `opcode`/`sig` selector every cycle.
- Decodes the instruction register, steps each instruction through fetch/decode/execute/memory/writeback, and drives every datapath write enable and mux select.
- Handles memory wait states, arithmetic overflow and illegal opcodes.

Parameters:
- MEM_WAIT_MAX, 15: cycles `mem_ready` may stay low before `timeout` is raised and the FSM halts.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  32  instruction register contents (valid from DECODE onward)
- alu_zero  in  1  ALU_out == 0, from datapath
- alu_overflow  in  1  ALU Overflow flag
- mem_ready  in  1  memory completes current access this cycle
- alu_opcode  out  6  ALU operation select
- alu_sig  out  1  ALU table select: 1 = R-type/funct table, 0 = I-type/opcode table
- alu_src_a  out  1  0 = PC, 1 = rs register
- alu_src_b  out  2  0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (with mem_req)
- addr_sel  out  1  0 = PC, 1 = ALUOut
- ir_we  out  1  load instruction register
- pc_we  out  1  load PC
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = {PC[31:28],instr[25:0],2'b00}, 3 = rs
- rf_we  out  1  register-file write
- reg_dst  out  2  0 = rt, 1 = rd, 2 = r31
- wb_sel  out  2  0 = ALUOut, 1 = memory data, 2 = PC
- exc  out  1  one-cycle overflow-exception pulse
- halted  out  1  FSM in HALT
- state  out  4  current state, for debug

Behaviour:
- Reset:
  - rst asserted -> state = FETCH (0), overflow latch cleared, wait counter cleared.
  - While rst is high, every enable (`pc_we`, `ir_we`, `rf_we`, `mem_req`, `mem_we`) and `exc` = 0, `halted` = 0.
  - rst mid-instruction abandons it; no partial writes.
- Outputs: Moore from state plus decoded fields `op` = instr[31:26], `fn` = instr[5:0]. Unlisted outputs = 0 in each state.
- States and transitions:
  - FETCH (0): mem_req=1, addr_sel=0, alu_sig=1, alu_opcode=0x21 (ADDU), src_a=0, src_b=1.
    - On mem_ready: ir_we=1, pc_we=1, pc_src=0, -> DECODE.
    - Otherwise stay; no enables.
  - DECODE (1): alu_sig=1, opcode 0x21, src_a=0, src_b=3; ALUOut captures branch target. Next state:
    - op 0x00 with fn 0x08 or 0x09 -> JUMP
    - op 0x00 with fn in {00,02,03,04,06,20-26,2A,2B} -> EXEC_R
    - op 0x02 or 0x03 -> JUMP
    - op 0x04 or 0x05 -> BRANCH
    - op 0x08-0x0F -> EXEC_I
    - op 0x23 or 0x2B -> ADDR
    - anything else -> HALT
  - EXEC_R (2): alu_sig=1, alu_opcode=fn, src_a=1, src_b=0; latch alu_overflow; -> WB. (Shift instructions take shamt inside the datapath.)
  - EXEC_I (3): alu_sig=0, alu_opcode=op, src_a=1, src_b=2; latch alu_overflow; -> WB.
  - ADDR (4): alu_sig=0, alu_opcode=op, src_a=1, src_b=2; -> MEM_RD if op=0x23, else MEM_WR.
  - MEM_RD (5): mem_req=1, addr_sel=1; wait for mem_ready; then -> LOAD_WB.
  - MEM_WR (6): mem_req=1, mem_we=1, addr_sel=1; wait for mem_ready; then -> FETCH.
  - LOAD_WB (7): rf_we=1, reg_dst=0, wb_sel=1; -> FETCH.
  - WB (8): reg_dst=1 for R-type, 0 for I-type; wb_sel=0.
    - Overflow latch set -> rf_we=0, exc=1 for this cycle.
    - Otherwise rf_we=1.
    - -> FETCH.
  - BRANCH (9): alu_sig=1, alu_opcode=0x23 (SUBU), src_a=1, src_b=0.
    - pc_we = alu_zero for op 0x04, = !alu_zero for op 0x05; pc_src=1.
    - -> FETCH.
  - JUMP (10): pc_we=1.
    - op 0x02: pc_src=2.
    - op 0x03: also rf_we=1, reg_dst=2, wb_sel=2.
    - fn 0x08: pc_src=3.
    - fn 0x09: pc_src=3, rf_we=1, reg_dst=1, wb_sel=2.
    - RF write uses the PC value before the update (PC+4).
    - -> FETCH.
  - HALT (15): halted=1, all enables 0; leaves only on rst.
- Overflow handling:
  - Latch samples `alu_overflow` only in EXEC_R/EXEC_I; cleared on entry to FETCH.
  - Overflow in any other state is ignored.
- Wait timeout:
  - Counter increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0; cleared when mem_ready=1 or on state change.
  - Reaching MEM_WAIT_MAX -> HALT.
- mem_ready asserted outside a memory state: ignored.

Test Plan:
- Reset during MEM_WR with mem_we high -> mem_we drops same cycle (async); after release state=0, pc_we rises only with mem_ready.
- instr=0x012A4020 (add $8,$9,$10), mem_ready tied 1 -> states 0,1,2,8; alu_sig=1/opcode=0x20 in EXEC_R; rf_we=1, reg_dst=1 in WB; 4 cycles total.
- Same add with alu_overflow=1 in EXEC_R -> WB has rf_we=0, exc=1 for exactly one cycle; next FETCH exc=0.
- lw 0x8D280004, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles; LOAD_WB asserts rf_we, wb_sel=1, reg_dst=0.
- beq with alu_zero=1 -> pc_we=1, pc_src=1 in BRANCH; bne with alu_zero=1 -> pc_we=0.
- instr opcode 0x3F -> DECODE->HALT, halted=1 stays; a separate run with mem_ready=0 for 15 FETCH cycles -> HALT.
